// File: rtl/mt8816_shadow.sv
// Passive monitor and shadow of an MT8816 crosspoint control bus: decodes strobe cycles,
// keeps a 16x8 crosspoint image, flags timing faults. Optional AX pin remap: MT8816_AX_REMAP_EN.
`timescale 1ns/1ps
module mt8816_shadow #(
  parameter int MIN_STROBE_CYCLES   = 2,
  parameter int MIN_CS_SETUP_CYCLES = 1,
  parameter int CNT_W               = 16
) (
  input  logic             FPGA_CLK_I,
  input  logic             RESET_N_I,
  input  logic             SW_RESET_I,
  input  logic             SW_CS_I,
  input  logic             SW_STROBE_I,
  input  logic [3:0]       SW_AX_I,
  input  logic [2:0]       SW_AY_I,
  input  logic             SW_DATA_I,
  input  logic             RD_EN_I,
  input  logic [2:0]       RD_AY_I,
  output logic [15:0]      RD_ROW_O,
  output logic             RD_VALID_O,
  output logic [127:0]     SW_STATE_O,
  output logic [CNT_W-1:0] WR_CNT_O,
  input  logic             ERR_CLR_I,
  output logic             ERR_STROBE_O,
  output logic             ERR_CS_O,
  output logic             ERR_ADDR_O
);

  localparam int WC_W = $clog2(MIN_STROBE_CYCLES + 1) + 1;
  localparam int SC_W = $clog2(MIN_CS_SETUP_CYCLES + 1) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_CLEAR} state_t;

  // Physical-to-logical column translation for the swapped board pins.
  function automatic logic [3:0] ax_remap(input logic [3:0] ax);
`ifdef MT8816_AX_REMAP_EN
    case (ax)
      4'h8:    return 4'h6;
      4'h9:    return 4'h7;
      4'hA:    return 4'h8;
      4'hB:    return 4'h9;
      4'hC:    return 4'hA;
      4'hD:    return 4'hB;
      4'h6:    return 4'hC;
      4'h7:    return 4'hD;
      default: return ax;
    endcase
`else
    return ax;
`endif
  endfunction

  logic             r_swrst, r_cs, r_stb, r_stb_d, r_data;
  logic [3:0]       r_ax;
  logic [2:0]       r_ay;
  state_t           r_state, w_nxt;
  logic [WC_W-1:0]  r_wcnt;
  logic [SC_W-1:0]  r_scnt;
  logic [3:0]       r_lat_ax;
  logic [2:0]       r_lat_ay;
  logic             r_lat_data, r_addr_bad, r_cs_bad;
  logic             r_cmt, r_cmt_data;
  logic [6:0]       r_cmt_idx;
  logic [127:0]     r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rd_en, r_rd_vld;
  logic [2:0]       r_rd_ay;
  logic [15:0]      r_rd_row;
  logic             r_err_stb, r_err_cs, r_err_addr;

  logic             w_rise, w_enter_stb, w_end_stb, w_setup_start, w_setup_inc;
  logic             w_setup_ok, w_width_ok, w_cmt;
  logic [3:0]       w_ax;
  logic [SC_W-1:0]  w_scnt_eff;

  // Single sampling stage; the delayed strobe copy gives edge detection.
  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_swrst <= 1'b0; r_cs <= 1'b0; r_stb <= 1'b0; r_stb_d <= 1'b0;
      r_data  <= 1'b0; r_ax <= '0;   r_ay  <= '0;
    end else begin
      r_swrst <= SW_RESET_I;
      r_cs    <= SW_CS_I;
      r_stb   <= SW_STROBE_I;
      r_stb_d <= r_stb;
      r_data  <= SW_DATA_I;
      r_ax    <= SW_AX_I;
      r_ay    <= SW_AY_I;
    end
  end

  assign w_rise     = r_stb & ~r_stb_d;
  assign w_ax       = ax_remap(r_ax);
  // Setup only counts while genuinely in SETUP; a strobe straight out of IDLE had none.
  assign w_scnt_eff = (r_state == ST_SETUP) ? r_scnt : '0;
  assign w_setup_ok = int'(w_scnt_eff) >= MIN_CS_SETUP_CYCLES;
  assign w_width_ok = int'(r_wcnt) >= MIN_STROBE_CYCLES;

  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) r_state <= ST_IDLE;
    else            r_state <= w_nxt;
  end

  always_comb begin
    w_nxt         = r_state;
    w_enter_stb   = 1'b0;
    w_end_stb     = 1'b0;
    w_setup_start = 1'b0;
    w_setup_inc   = 1'b0;
    if (r_swrst) begin
      w_nxt = ST_CLEAR;
    end else begin
      case (r_state)
        ST_CLEAR: w_nxt = ST_IDLE;
        ST_IDLE: begin
          if (w_rise) begin
            w_nxt = ST_STROBE; w_enter_stb = 1'b1;
          end else if (r_cs) begin
            w_nxt = ST_SETUP; w_setup_start = 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_rise) begin
            w_nxt = ST_STROBE; w_enter_stb = 1'b1;
          end else if (!r_cs) begin
            w_nxt = ST_IDLE;
          end else begin
            w_setup_inc = 1'b1;
          end
        end
        ST_STROBE: begin
          if (!r_stb) begin
            w_end_stb     = 1'b1;
            w_nxt         = r_cs ? ST_SETUP : ST_IDLE;
            w_setup_start = r_cs;
          end
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_scnt <= '0; r_wcnt <= '0; r_lat_ax <= '0; r_lat_ay <= '0;
      r_lat_data <= 1'b0; r_addr_bad <= 1'b0; r_cs_bad <= 1'b0;
    end else begin
      if (w_setup_start)                    r_scnt <= {{(SC_W-1){1'b0}}, 1'b1};
      else if (w_setup_inc && r_scnt != '1) r_scnt <= r_scnt + 1'b1;
      if (w_enter_stb) begin
        r_wcnt     <= {{(WC_W-1){1'b0}}, 1'b1};
        r_lat_ax   <= w_ax;
        r_lat_ay   <= r_ay;
        r_lat_data <= r_data;
        r_addr_bad <= 1'b0;
        r_cs_bad   <= ~(r_cs & w_setup_ok);
      end else if (r_state == ST_STROBE && r_stb && !r_swrst) begin
        if (r_wcnt != '1) r_wcnt <= r_wcnt + 1'b1;
        if ({w_ax, r_ay, r_data} != {r_lat_ax, r_lat_ay, r_lat_data}) r_addr_bad <= 1'b1;
      end
    end
  end

  assign w_cmt = w_end_stb & w_width_ok & ~r_cs_bad & ~r_addr_bad;

  // Commit is staged one clock so the shadow update lands two clocks after the low sample.
  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_cmt <= 1'b0; r_cmt_idx <= '0; r_cmt_data <= 1'b0;
      r_shadow <= '0; r_cnt <= '0;
    end else begin
      r_cmt      <= w_cmt;
      r_cmt_idx  <= {r_lat_ay, r_lat_ax};
      r_cmt_data <= r_lat_data;
      if (r_state == ST_CLEAR) r_shadow <= '0;
      else if (r_cmt)          r_shadow[r_cmt_idx] <= r_cmt_data;
      if (r_cmt && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  // A new error in the clearing cycle must survive, so set wins over clear.
  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_err_stb <= 1'b0; r_err_cs <= 1'b0; r_err_addr <= 1'b0;
    end else begin
      r_err_stb  <= (r_err_stb  & ~ERR_CLR_I) | (w_end_stb & ~w_width_ok);
      r_err_cs   <= (r_err_cs   & ~ERR_CLR_I) | (w_enter_stb & ~(r_cs & w_setup_ok));
      r_err_addr <= (r_err_addr & ~ERR_CLR_I) | (w_end_stb & r_addr_bad);
    end
  end

  always_ff @(posedge FPGA_CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_rd_en <= 1'b0; r_rd_ay <= '0; r_rd_vld <= 1'b0; r_rd_row <= '0;
    end else begin
      r_rd_en  <= RD_EN_I;
      r_rd_ay  <= RD_AY_I;
      r_rd_vld <= r_rd_en;
      if (r_rd_en) r_rd_row <= r_shadow[{r_rd_ay, 4'b0000} +: 16];
    end
  end

  assign RD_ROW_O     = r_rd_row;
  assign RD_VALID_O   = r_rd_vld;
  assign SW_STATE_O   = r_shadow;
  assign WR_CNT_O     = r_cnt;
  assign ERR_STROBE_O = r_err_stb;
  assign ERR_CS_O     = r_err_cs;
  assign ERR_ADDR_O   = r_err_addr;

endmodule

// File: tb/tb_mt8816_shadow.sv
// Scoreboard bench for mt8816_shadow: bus cycles update a reference shadow,
// readback expectations are queued at request time and popped on RD_VALID_O.
`timescale 1ns/1ps
module tb_mt8816_shadow;
  localparam int CW = 6;
`ifdef MT8816_AX_REMAP_EN
  localparam int REMAP_BIT = 6;
`else
  localparam int REMAP_BIT = 8;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic SW_RESET_I = 0, SW_CS_I = 0, SW_STROBE_I = 0, SW_DATA_I = 0;
  logic [3:0] SW_AX_I = '0;
  logic [2:0] SW_AY_I = '0, RD_AY_I = '0;
  logic RD_EN_I = 0, ERR_CLR_I = 0;
  logic [15:0] RD_ROW_O;
  logic RD_VALID_O, ERR_STROBE_O, ERR_CS_O, ERR_ADDR_O;
  logic [127:0] SW_STATE_O;
  logic [CW-1:0] WR_CNT_O;

  int n_chk = 0, n_pass = 0;
  logic [127:0] mdl = '0;
  logic [CW-1:0] cnt = '0;
  bit e_stb = 0, e_cs = 0, e_addr = 0;
  logic [15:0] rdq[$];
  logic [15:0] mon_exp, last_row;

  mt8816_shadow #(.MIN_STROBE_CYCLES(2), .MIN_CS_SETUP_CYCLES(1), .CNT_W(CW)) dut (
    .FPGA_CLK_I(clk), .RESET_N_I(rst_n), .SW_RESET_I(SW_RESET_I), .SW_CS_I(SW_CS_I),
    .SW_STROBE_I(SW_STROBE_I), .SW_AX_I(SW_AX_I), .SW_AY_I(SW_AY_I), .SW_DATA_I(SW_DATA_I),
    .RD_EN_I(RD_EN_I), .RD_AY_I(RD_AY_I), .RD_ROW_O(RD_ROW_O), .RD_VALID_O(RD_VALID_O),
    .SW_STATE_O(SW_STATE_O), .WR_CNT_O(WR_CNT_O), .ERR_CLR_I(ERR_CLR_I),
    .ERR_STROBE_O(ERR_STROBE_O), .ERR_CS_O(ERR_CS_O), .ERR_ADDR_O(ERR_ADDR_O));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, obs, exp);
  endtask

  function automatic logic [3:0] map_ax(input logic [3:0] ax);
`ifdef MT8816_AX_REMAP_EN
    case (ax)
      4'h8: return 4'h6;  4'h9: return 4'h7;  4'hA: return 4'h8;  4'hB: return 4'h9;
      4'hC: return 4'hA;  4'hD: return 4'hB;  4'h6: return 4'hC;  4'h7: return 4'hD;
      default: return ax;
    endcase
`else
    return ax;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && RD_VALID_O) begin
      if (rdq.size() == 0) chk("rd_spurious", 1, 0);
      else begin
        mon_exp = rdq.pop_front();
        chk("rd_row", RD_ROW_O, mon_exp);
      end
    end
  end

  task automatic chk_err(input string tag);
    chk(tag, {ERR_STROBE_O, ERR_CS_O, ERR_ADDR_O}, {e_stb, e_cs, e_addr});
  endtask

  task automatic bus_wr(input logic [3:0] ax, input logic [2:0] ay, input logic d,
                        input int setup, input int width, input bit glitch,
                        input bit use_cs, input bit lat);
    logic [127:0] pre;
    bit ok;
    ok  = use_cs && setup >= 1 && width >= 2 && !glitch;
    pre = mdl;
    if (use_cs) begin SW_CS_I = 1; repeat (setup) @(negedge clk); end
    SW_AX_I = ax; SW_AY_I = ay; SW_DATA_I = d; SW_STROBE_I = 1;
    @(negedge clk);
    if (glitch) SW_AX_I = ax + 4'd1;
    repeat (width - 1) @(negedge clk);
    SW_STROBE_I = 0;
    repeat (2) @(negedge clk);
    if (lat) chk("cmt_early", SW_STATE_O, pre);
    @(negedge clk);
    if (width < 2) e_stb = 1;
    if (!use_cs || setup < 1) e_cs = 1;
    if (glitch) e_addr = 1;
    if (ok) begin
      mdl[{ay, map_ax(ax)}] = d;
      if (cnt != '1) cnt = cnt + 1'b1;
    end
    if (lat) chk("cmt_lat", SW_STATE_O, mdl);
    SW_CS_I = 0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] ay);
    RD_EN_I = 1; RD_AY_I = ay;
    rdq.push_back(mdl[{ay, 4'b0000} +: 16]);
    @(negedge clk);
    RD_EN_I = 0;
    chk("rd_vld_early", RD_VALID_O, 0);
    @(negedge clk);
    chk("rd_vld", RD_VALID_O, 1);
    last_row = mdl[{ay, 4'b0000} +: 16];
    @(negedge clk);
    chk("rd_hold", RD_ROW_O, last_row);
  endtask

  task automatic clr_err();
    ERR_CLR_I = 1; @(negedge clk); ERR_CLR_I = 0;
    e_stb = 0; e_cs = 0; e_addr = 0;
    chk_err("err_clr");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ax;
    logic [2:0] ay;
    logic d;
    repeat (3) @(negedge clk);
    chk("rst_state", SW_STATE_O, 0);
    chk("rst_cnt", WR_CNT_O, 0);
    chk("rst_rd", {RD_VALID_O, RD_ROW_O}, 0);
    chk_err("rst_err");
    rst_n = 1;
    repeat (2) @(negedge clk);

    // legal write with latency checks, then readback of row 2
    bus_wr(4'd3, 3'd2, 1'b1, 1, 2, 0, 1, 1);
    chk("bit35", SW_STATE_O[35], 1);
    chk("cnt1", WR_CNT_O, cnt);
    chk_err("legal_err");
    rd(3'd2);

    bus_wr(4'h8, 3'd0, 1'b1, 1, 2, 0, 1, 1);
    chk("remap_bit", SW_STATE_O[REMAP_BIT], 1);

    for (int i = 0; i < 20; i++) begin
      ax = 4'($urandom_range(0, 15));
      ay = 3'($urandom_range(0, 7));
      d  = 1'($urandom_range(0, 1));
      bus_wr(ax, ay, d, $urandom_range(1, 3), $urandom_range(2, 4), 0, 1, 0);
      chk("rand_wr", SW_STATE_O, mdl);
    end
    chk("rand_cnt", WR_CNT_O, cnt);
    for (int r = 0; r < 8; r++) rd(3'(r));

    bus_wr(4'd5, 3'd6, 1'b1, 1, 1, 0, 1, 1);
    chk_err("short_stb");
    clr_err();
    bus_wr(4'd3, 3'd4, 1'b1, 1, 3, 1, 1, 1);
    chk_err("addr_glitch");
    clr_err();
    bus_wr(4'd1, 3'd1, 1'b1, 1, 2, 0, 0, 1);
    chk_err("no_cs");
    clr_err();
    bus_wr(4'd2, 3'd3, 1'b1, 0, 2, 0, 1, 1);
    chk_err("setup0");
    clr_err();

    // new short-strobe error lands in the same cycle as ERR_CLR_I
    bus_wr(4'd0, 3'd0, 1'b1, 1, 1, 0, 1, 0);
    SW_CS_I = 1; @(negedge clk);
    SW_STROBE_I = 1; @(negedge clk);
    SW_STROBE_I = 0; @(negedge clk);
    ERR_CLR_I = 1; @(negedge clk);
    ERR_CLR_I = 0; repeat (2) @(negedge clk);
    SW_CS_I = 0; @(negedge clk);
    chk_err("clr_vs_set");
    chk("clr_vs_set_state", SW_STATE_O, mdl);
    clr_err();

    for (int k = 0; k < 128; k++) bus_wr(4'(k % 16), 3'(k / 16), 1'b1, 1, 2, 0, 1, 0);
    chk("fill", SW_STATE_O, {128{1'b1}});
    chk("cnt_sat", WR_CNT_O, cnt);

    SW_RESET_I = 1; SW_CS_I = 1; @(negedge clk);
    SW_AX_I = 4'd7; SW_AY_I = 3'd7; SW_DATA_I = 1; SW_STROBE_I = 1; @(negedge clk);
    SW_STROBE_I = 0; repeat (2) @(negedge clk);
    SW_RESET_I = 0; SW_CS_I = 0; repeat (4) @(negedge clk);
    mdl = '0;
    chk("clear_state", SW_STATE_O, mdl);
    chk("clear_cnt", WR_CNT_O, cnt);
    chk_err("clear_err");

    // read sampled one edge before the shadow write must see pre-commit row
    SW_CS_I = 1; @(negedge clk);
    SW_AX_I = 4'd9; SW_AY_I = 3'd5; SW_DATA_I = 1; SW_STROBE_I = 1;
    repeat (2) @(negedge clk);
    SW_STROBE_I = 0; @(negedge clk);
    RD_EN_I = 1; RD_AY_I = 3'd5;
    rdq.push_back(mdl[{3'd5, 4'b0000} +: 16]);
    @(negedge clk);
    RD_EN_I = 0; @(negedge clk);
    mdl[{3'd5, map_ax(4'd9)}] = 1'b1;
    chk("coll_state", SW_STATE_O, mdl);
    SW_CS_I = 0; repeat (2) @(negedge clk);
    rd(3'd5);

    bus_wr(4'd4, 3'd4, 1'b1, 1, 1, 0, 1, 0);
    chk_err("pre_rst_err");
    SW_CS_I = 1; SW_AX_I = 4'd2; SW_AY_I = 3'd1; SW_STROBE_I = 1;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_state", SW_STATE_O, 0);
    chk("rst_mid_cnt", WR_CNT_O, 0);
    chk("rst_mid_rd", {RD_VALID_O, RD_ROW_O}, 0);
    chk("rst_mid_err", {ERR_STROBE_O, ERR_CS_O, ERR_ADDR_O}, 0);
    @(negedge clk);
    SW_STROBE_I = 0; SW_CS_I = 0;
    @(negedge clk); rst_n = 1;
    repeat (6) @(negedge clk);
    chk("post_rst_state", SW_STATE_O, 0);
    chk("post_rst_cnt", WR_CNT_O, 0);

    chk("rdq_empty", rdq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
